// File: rtl/sprite_table.sv
// Double-buffered sprite attribute table: host writes a shadow bank, frame_sync commits it to the active bank.
// Latency: reads return one cycle after rd_en; a commit takes NUM_SPRITES cycles, commit_done one cycle after the last copy.
// Backpressure: none; writes are always accepted (out-of-range ones dropped). Define SPRITE_TABLE_ERR_EN to enable the sticky wr_err/overrun flags.
module sprite_table #(
    parameter int NUM_SPRITES = 20,
    parameter int ENTRY_W     = 24,
    parameter int IDX_W       = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               write,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               frame_sync,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               err_clr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               dirty,
    output logic               commit_done,
    output logic               wr_err,
    output logic               overrun
);

    // The index must be able to address every entry.
    if ((2 ** IDX_W) < NUM_SPRITES) begin : g_idx_too_narrow
        $error("sprite_table: IDX_W too small for NUM_SPRITES");
    end

    typedef enum logic {IDLE, COPY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               dirty_q, dirty_d;
    logic               commit_done_q, commit_done_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
    logic [ENTRY_W-1:0] shadow_q [NUM_SPRITES];
    logic [ENTRY_W-1:0] shadow_d [NUM_SPRITES];
    logic [ENTRY_W-1:0] active_q [NUM_SPRITES];
    logic [ENTRY_W-1:0] active_d [NUM_SPRITES];
    logic               wr_in_range;

    assign wr_in_range = (32'(wr_idx) < NUM_SPRITES);

    // Shadow writes, commit sequencing and the dirty flag; a write always wins over the commit-start clear.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        dirty_d       = dirty_q;
        commit_done_d = 1'b0;
        shadow_d      = shadow_q;
        active_d      = active_q;

        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (write && (wr_idx == IDX_W'(i))) begin
                shadow_d[i] = wr_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_sync && dirty_q) begin
                    state_d = COPY;
                    ptr_d   = '0;
                    dirty_d = 1'b0;
                end
            end
            COPY: begin
                // Copy from shadow_d so a same-cycle write to the entry under the pointer is picked up.
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (ptr_q == IDX_W'(i)) begin
                        active_d[i] = shadow_d[i];
                    end
                end
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(NUM_SPRITES - 1)) begin
                    state_d       = IDLE;
                    ptr_d         = '0;
                    commit_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (write && wr_in_range) begin
            dirty_d = 1'b1;
        end
    end

    // Read port samples the active bank before this cycle's copy lands; out-of-range reads return zero.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data_d = active_q[i];
                end
            end
        end
    end

    // State, pointer, flags and both banks; reset abandons any copy in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            dirty_q       <= 1'b0;
            commit_done_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

`ifdef SPRITE_TABLE_ERR_EN
    logic wr_err_q, wr_err_d;
    logic overrun_q, overrun_d;

    // Sticky error flags: clear first so a simultaneous set event wins.
    always_comb begin
        wr_err_d  = wr_err_q;
        overrun_d = overrun_q;
        if (err_clr) begin
            wr_err_d  = 1'b0;
            overrun_d = 1'b0;
        end
        if (write && !wr_in_range) begin
            wr_err_d = 1'b1;
        end
        if (frame_sync && (state_q == COPY)) begin
            overrun_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_err_q  <= wr_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_err  = wr_err_q;
    assign overrun = overrun_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign wr_err         = 1'b0;
    assign overrun        = 1'b0;
`endif

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = (state_q == COPY);
    assign dirty       = dirty_q;
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_sprite_table.sv
// Self-checking bench for sprite_table: vector table, directed commit/reset sequences, random traffic vs a bank-level model.
// Latency: model predicts outputs one clock after the inputs that cause them.
// Backpressure: none at this interface.
module tb_sprite_table;
    localparam int N  = 20;
    localparam int EW = 24;
    localparam int IW = 5;
`ifdef SPRITE_TABLE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          write, frame_sync, rd_en, err_clr;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;
    logic          rd_valid, busy, dirty, commit_done, wr_err, overrun;

    sprite_table #(.NUM_SPRITES(N), .ENTRY_W(EW), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .write(write), .wr_idx(wr_idx), .wr_data(wr_data),
        .frame_sync(frame_sync), .rd_en(rd_en), .rd_idx(rd_idx), .err_clr(err_clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .dirty(dirty),
        .commit_done(commit_done), .wr_err(wr_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: two banks, a dirty bit, and a commit in progress counted in entries.
    logic [EW-1:0] m_shadow [N];
    logic [EW-1:0] m_active [N];
    bit            m_dirty, m_busy;
    int            m_cnt;
    logic [EW-1:0] e_rd_data;
    bit            e_rd_valid, e_cd, e_wr_err, e_overrun;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_dirty = 0; m_busy = 0; m_cnt = 0;
        e_rd_data = '0; e_rd_valid = 0; e_cd = 0; e_wr_err = 0; e_overrun = 0;
    endtask

    // One clock of the model, using the inputs held during that clock.
    task automatic m_step();
        bit was_busy  = m_busy;
        bit was_dirty = m_dirty;
        bit in_range  = (int'(wr_idx) < N);
        e_rd_valid = rd_en;
        if (rd_en) e_rd_data = (int'(rd_idx) < N) ? m_active[rd_idx] : '0;
        if (err_clr) begin
            e_wr_err  = 0;
            e_overrun = 0;
        end
        if (write && in_range) m_shadow[wr_idx] = wr_data;
        if (write && !in_range && ERR_EN) e_wr_err = 1;
        e_cd = 0;
        if (was_busy) begin
            m_active[m_cnt] = m_shadow[m_cnt];
            m_cnt++;
            if (frame_sync && ERR_EN) e_overrun = 1;
            if (m_cnt == N) begin
                m_busy = 0;
                e_cd   = 1;
            end
        end else if (frame_sync && was_dirty) begin
            m_busy  = 1;
            m_cnt   = 0;
            m_dirty = 0;
        end
        if (write && in_range) m_dirty = 1;
    endtask

    task automatic check_outputs();
        chk("rd_data", 32'(rd_data), 32'(e_rd_data));
        chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("dirty", 32'(dirty), 32'(m_dirty));
        chk("commit_done", 32'(commit_done), 32'(e_cd));
        chk("wr_err", 32'(wr_err), 32'(e_wr_err));
        chk("overrun", 32'(overrun), 32'(e_overrun));
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        write = 0; wr_idx = '0; wr_data = '0; frame_sync = 0;
        rd_en = 0; rd_idx = '0; err_clr = 0;
    endtask

    task automatic do_write(input int idx, input logic [EW-1:0] d);
        write = 1; wr_idx = IW'(idx); wr_data = d;
        cycle();
        write = 0;
    endtask

    task automatic do_read(input string name, input int idx, input logic [EW-1:0] exp);
        rd_en = 1; rd_idx = IW'(idx);
        cycle();
        rd_en = 0;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    // Run until commit_done is seen (bounded); reports busy samples and pulses seen.
    task automatic wait_commit(input string name, output int busy_n, output int cd_n);
        busy_n = 0; cd_n = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (busy) busy_n++;
            if (commit_done) cd_n++;
        end
        if (cd_n == 0) chk(name, 32'(cd_n), 32'd1);
    endtask

    typedef struct {
        bit            wr;
        logic [IW-1:0] widx;
        logic [EW-1:0] wdat;
        bit            re;
        logic [IW-1:0] ridx;
        logic [EW-1:0] x_rd_data;
        bit            x_rd_valid;
        bit            x_dirty;
        bit            x_busy;
    } vec_t;

    vec_t vt [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bn, cn;
        vt[0] = '{1, 5'd3,  24'hABCDEF, 0, 5'd0,  24'h0, 0, 1, 0};
        vt[1] = '{0, 5'd0,  24'h0,      1, 5'd3,  24'h0, 1, 1, 0};
        vt[2] = '{0, 5'd0,  24'h0,      0, 5'd0,  24'h0, 0, 1, 0};
        vt[3] = '{1, 5'd25, 24'h123456, 0, 5'd0,  24'h0, 0, 1, 0};
        vt[4] = '{0, 5'd0,  24'h0,      1, 5'd25, 24'h0, 1, 1, 0};
        vt[5] = '{1, 5'd7,  24'h000077, 0, 5'd0,  24'h0, 0, 1, 0};
        vt[6] = '{0, 5'd0,  24'h0,      1, 5'd7,  24'h0, 1, 1, 0};

        idle_inputs();
        reset_n = 0;
        m_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dirty", 32'(dirty), 32'd0);

        // Vector table: writes/reads before any commit.
        for (int v = 0; v < 7; v++) begin
            write = vt[v].wr; wr_idx = vt[v].widx; wr_data = vt[v].wdat;
            rd_en = vt[v].re; rd_idx = vt[v].ridx;
            cycle();
            chk($sformatf("vec%0d_rd_data", v), 32'(rd_data), 32'(vt[v].x_rd_data));
            chk($sformatf("vec%0d_rd_valid", v), 32'(rd_valid), 32'(vt[v].x_rd_valid));
            chk($sformatf("vec%0d_dirty", v), 32'(dirty), 32'(vt[v].x_dirty));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].x_busy));
        end
        idle_inputs();
        chk("wr_err_sticky", 32'(wr_err), 32'(ERR_EN));
        err_clr = 1; cycle(); err_clr = 0;
        chk("wr_err_cleared", 32'(wr_err), 32'd0);

        // Commit: busy for exactly N cycles, one commit_done pulse.
        frame_sync = 1; cycle(); frame_sync = 0;
        bn = busy ? 1 : 0;
        begin
            int b2, c2;
            wait_commit("commitA_seen", b2, c2);
            chk("commitA_busy_cycles", 32'(bn + b2), 32'(N));
            chk("commitA_pulses", 32'(c2), 32'd1);
        end
        chk("commitA_dirty", 32'(dirty), 32'd0);
        do_read("commitA_rd3", 3, 24'hABCDEF);
        do_read("commitA_rd7", 7, 24'h000077);

        // frame_sync with nothing dirty: no commit.
        frame_sync = 1; cycle(); frame_sync = 0;
        chk("clean_fs_busy", 32'(busy), 32'd0);
        bn = 0; cn = 0;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (busy) bn++;
            if (commit_done) cn++;
        end
        chk("clean_fs_busy_cycles", 32'(bn), 32'd0);
        chk("clean_fs_pulses", 32'(cn), 32'd0);
        do_read("clean_fs_rd3", 3, 24'hABCDEF);

        // Writes during a copy at ptr=5 plus an overrun frame_sync.
        do_write(0, 24'h000005);
        frame_sync = 1; cycle(); frame_sync = 0;
        repeat (5) cycle();
        write = 1; wr_idx = 5'd2; wr_data = 24'h111111; frame_sync = 1;
        cycle();
        frame_sync = 0; wr_idx = 5'd10; wr_data = 24'h222222;
        cycle();
        write = 0;
        wait_commit("commitC_seen", bn, cn);
        chk("commitC_pulses", 32'(cn), 32'd1);
        chk("commitC_dirty", 32'(dirty), 32'd1);
        chk("commitC_overrun", 32'(overrun), 32'(ERR_EN));
        do_read("commitC_rd10", 10, 24'h222222);
        do_read("commitC_rd2_old", 2, 24'h000000);
        do_read("commitC_rd0", 0, 24'h000005);
        err_clr = 1; cycle(); err_clr = 0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        frame_sync = 1; cycle(); frame_sync = 0;
        wait_commit("commitD_seen", bn, cn);
        do_read("commitD_rd2", 2, 24'h111111);

        // Out-of-range write leaves dirty and shadow alone.
        do_write(25, 24'h123456);
        chk("oor_dirty", 32'(dirty), 32'd0);
        chk("oor_wr_err", 32'(wr_err), 32'(ERR_EN));
        do_read("oor_rd25", 25, 24'h0);
        err_clr = 1; cycle(); err_clr = 0;
        chk("oor_wr_err_clr", 32'(wr_err), 32'd0);

        // Reset at copy cycle 8: everything clears at once, no commit_done afterwards.
        do_write(4, 24'hAAAAAA);
        do_read("pre_reset_rd3", 3, 24'hABCDEF);
        frame_sync = 1; cycle(); frame_sync = 0;
        repeat (8) cycle();
        chk("midcopy_busy", 32'(busy), 32'd1);
        reset_n = 0;
        m_reset();
        #1;
        check_outputs();
        chk("async_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        cn = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (commit_done) cn++;
        end
        chk("post_reset_pulses", 32'(cn), 32'd0);
        do_read("post_reset_rd3", 3, 24'h0);
        do_read("post_reset_rd4", 4, 24'h0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            write      = ($urandom_range(0, 3) == 0);
            wr_idx     = IW'($urandom_range(0, 31));
            wr_data    = EW'($urandom);
            frame_sync = ($urandom_range(0, 29) == 0);
            rd_en      = ($urandom_range(0, 1) == 0);
            rd_idx     = IW'($urandom_range(0, 31));
            err_clr    = ($urandom_range(0, 49) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
